// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// regfile_write_arbiter: single write port of the register file, shared by two
// round-robin requesters and a bulk clear sweep.  Rev 1.0
// ============================================================================
module regfile_write_arbiter #(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 2,
    parameter int                NUM_REGS    = 4,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_valid,
    input  logic [ADDR_W-1:0] r0_add,
    input  logic [DATA_W-1:0] r0_data,
    output logic              r0_ready,
    input  logic              r1_valid,
    input  logic [ADDR_W-1:0] r1_add,
    input  logic [DATA_W-1:0] r1_data,
    output logic              r1_ready,
    input  logic              clr_start,
    output logic              clr_done,
    output logic              busy,
    output logic              w_flag,
    output logic [ADDR_W-1:0] w_add,
    output logic [DATA_W-1:0] w_data,
    output logic              last_grant,
    output logic [7:0]        wr_cnt
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   idx, idx_nx;
    logic                rr_ptr, rr_nx;
    logic                wf_nx;
    logic [ADDR_W-1:0]   wa_nx;
    logic [DATA_W-1:0]   wd_nx;
    logic                done_nx;
    logic                lg_nx;
    logic [7:0]          cnt_nx;
    logic                port_free;
    logic                grant0, grant1;

    // Ready is held low while reset is asserted so every output reads 0.
    assign port_free = reset & (state == IDLE) & ~clr_start;
    assign grant0    = r0_valid & (~r1_valid | ~rr_ptr);
    assign grant1    = r1_valid & (~r0_valid |  rr_ptr);
    assign r0_ready  = port_free & grant0;
    assign r1_ready  = port_free & grant1;
    assign busy      = (state == CLEAR);

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        rr_nx    = rr_ptr;
        wf_nx    = 1'b0;
        wa_nx    = w_add;
        wd_nx    = w_data;
        done_nx  = 1'b0;
        lg_nx    = last_grant;
        cnt_nx   = wr_cnt;
        case (state)
            IDLE: begin
                if (clr_start) begin
                    // First clear write is issued on the same edge the sweep starts.
                    state_nx = CLEAR;
                    idx_nx   = '0;
                    wf_nx    = 1'b1;
                    wa_nx    = '0;
                    wd_nx    = CLEAR_VALUE;
                end else if (r0_ready) begin
                    wf_nx  = 1'b1;
                    wa_nx  = r0_add;
                    wd_nx  = r0_data;
                    rr_nx  = 1'b1;
                    lg_nx  = 1'b0;
                    cnt_nx = wr_cnt + 8'd1;
                end else if (r1_ready) begin
                    wf_nx  = 1'b1;
                    wa_nx  = r1_add;
                    wd_nx  = r1_data;
                    rr_nx  = 1'b0;
                    lg_nx  = 1'b1;
                    cnt_nx = wr_cnt + 8'd1;
                end
            end
            CLEAR: begin
                if (idx == LAST_IDX) begin
                    state_nx = IDLE;
                    idx_nx   = '0;
                    done_nx  = 1'b1;
                end else begin
                    idx_nx = idx + 1'b1;
                    wf_nx  = 1'b1;
                    wa_nx  = idx + 1'b1;
                    wd_nx  = CLEAR_VALUE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            idx        <= '0;
            rr_ptr     <= 1'b0;
            w_flag     <= 1'b0;
            w_add      <= '0;
            w_data     <= '0;
            clr_done   <= 1'b0;
            last_grant <= 1'b0;
            wr_cnt     <= 8'd0;
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            rr_ptr     <= rr_nx;
            w_flag     <= wf_nx;
            w_add      <= wa_nx;
            w_data     <= wd_nx;
            clr_done   <= done_nx;
            last_grant <= lg_nx;
            wr_cnt     <= cnt_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// tb_regfile_write_arbiter: vector table, directed corner sequences and a
// randomized run against a behavioural model of the write port.  Rev 1.0
// ============================================================================
module tb_regfile_write_arbiter;

    localparam int NREG = 4;

    logic        clk;
    logic        reset;
    logic        r0_valid, r1_valid, clr_start;
    logic [1:0]  r0_add, r1_add;
    logic [15:0] r0_data, r1_data;
    logic        r0_ready, r1_ready, clr_done, busy, w_flag, last_grant;
    logic [1:0]  w_add;
    logic [15:0] w_data;
    logic [7:0]  wr_cnt;

    int passed = 0;
    int total  = 0;

    regfile_write_arbiter #(
        .DATA_W(16), .ADDR_W(2), .NUM_REGS(4), .CLEAR_VALUE(16'h0000)
    ) dut (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_add(r0_add), .r0_data(r0_data), .r0_ready(r0_ready),
        .r1_valid(r1_valid), .r1_add(r1_add), .r1_data(r1_data), .r1_ready(r1_ready),
        .clr_start(clr_start), .clr_done(clr_done), .busy(busy),
        .w_flag(w_flag), .w_add(w_add), .w_data(w_data),
        .last_grant(last_grant), .wr_cnt(wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file being written, updated at the negedge as the real file is.
    logic [15:0] tb_file [NREG];
    always @(negedge clk) if (w_flag) tb_file[w_add] <= w_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " w_flag"},     32'(w_flag),     32'd0);
        check({tag, " w_add"},      32'(w_add),      32'd0);
        check({tag, " w_data"},     32'(w_data),     32'd0);
        check({tag, " busy"},       32'(busy),       32'd0);
        check({tag, " clr_done"},   32'(clr_done),   32'd0);
        check({tag, " last_grant"}, 32'(last_grant), 32'd0);
        check({tag, " wr_cnt"},     32'(wr_cnt),     32'd0);
        check({tag, " ready"},      32'({r0_ready, r1_ready}), 32'd0);
    endtask

    typedef struct {
        logic        r0v;
        logic [1:0]  r0a;
        logic [15:0] r0d;
        logic        r1v;
        logic [1:0]  r1a;
        logic [15:0] r1d;
        logic        e0;
        logic        e1;
        logic        ewf;
        logic [1:0]  ewa;
        logic [15:0] ewd;
        logic        elg;
        logic [7:0]  ecnt;
    } vec_t;

    vec_t vecs [9];

    // Behavioural model state for the randomized run
    logic [15:0] m_mem [NREG];
    bit          known [NREG];
    bit          m_active, m_rr, m_lg, e_done, e_wf, g, e0, e1, acc0, acc1;
    int          m_written;
    logic [7:0]  m_cnt;
    logic [1:0]  e_wa;
    logic [15:0] e_wd;
    int          rdy_cnt, wf_cnt;

    initial begin
        reset = 1'b0; clr_start = 1'b0;
        r0_valid = 1'b0; r0_add = '0; r0_data = '0;
        r1_valid = 1'b0; r1_add = '0; r1_data = '0;

        vecs[0] = '{1'b1, 2'd2, 16'hBEEF, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 2'd2, 16'hBEEF, 1'b0, 8'd1};
        vecs[1] = '{1'b0, 2'd0, 16'h0000, 1'b1, 2'd3, 16'h3333, 1'b0, 1'b1, 1'b1, 2'd3, 16'h3333, 1'b1, 8'd2};
        vecs[2] = '{1'b1, 2'd1, 16'h1111, 1'b1, 2'd1, 16'h2222, 1'b1, 1'b0, 1'b1, 2'd1, 16'h1111, 1'b0, 8'd3};
        vecs[3] = '{1'b0, 2'd1, 16'h1111, 1'b1, 2'd1, 16'h2222, 1'b0, 1'b1, 1'b1, 2'd1, 16'h2222, 1'b1, 8'd4};
        vecs[4] = '{1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd1, 16'h2222, 1'b1, 8'd4};
        vecs[5] = '{1'b1, 2'd0, 16'hAAAA, 1'b1, 2'd2, 16'h5555, 1'b1, 1'b0, 1'b1, 2'd0, 16'hAAAA, 1'b0, 8'd5};
        vecs[6] = '{1'b1, 2'd3, 16'hCCCC, 1'b1, 2'd2, 16'h5555, 1'b0, 1'b1, 1'b1, 2'd2, 16'h5555, 1'b1, 8'd6};
        vecs[7] = '{1'b1, 2'd3, 16'hCCCC, 1'b1, 2'd0, 16'hDDDD, 1'b1, 1'b0, 1'b1, 2'd3, 16'hCCCC, 1'b0, 8'd7};
        vecs[8] = '{1'b1, 2'd1, 16'hEEEE, 1'b1, 2'd0, 16'hDDDD, 1'b0, 1'b1, 1'b1, 2'd0, 16'hDDDD, 1'b1, 8'd8};

        // Reset state
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk) reset = 1'b1;

        // Table: single writers, same-address pair, idle cycle, alternating grants
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            r0_valid = vecs[i].r0v; r0_add = vecs[i].r0a; r0_data = vecs[i].r0d;
            r1_valid = vecs[i].r1v; r1_add = vecs[i].r1a; r1_data = vecs[i].r1d;
            #1;
            check($sformatf("vec%0d r0_ready", i), 32'(r0_ready), 32'(vecs[i].e0));
            check($sformatf("vec%0d r1_ready", i), 32'(r1_ready), 32'(vecs[i].e1));
            @(posedge clk); #1;
            check($sformatf("vec%0d w_flag", i),     32'(w_flag),     32'(vecs[i].ewf));
            check($sformatf("vec%0d w_add", i),      32'(w_add),      32'(vecs[i].ewa));
            check($sformatf("vec%0d w_data", i),     32'(w_data),     32'(vecs[i].ewd));
            check($sformatf("vec%0d last_grant", i), 32'(last_grant), 32'(vecs[i].elg));
            check($sformatf("vec%0d wr_cnt", i),     32'(wr_cnt),     32'(vecs[i].ecnt));
        end
        @(negedge clk);
        r0_valid = 1'b0; r1_valid = 1'b0;
        #1 check("same-addr reg1 final", 32'(tb_file[1]), 32'h2222);

        // Clear sweep beating a pending r1 request; clr_start during sweep ignored
        @(negedge clk);
        clr_start = 1'b1; r1_valid = 1'b1; r1_add = 2'd2; r1_data = 16'h7777;
        #1 check("clr start r1_ready", 32'(r1_ready), 32'd0);
        @(posedge clk); #1;
        check("clr w0", 32'({w_flag, w_add, w_data, busy, clr_done}), 32'({1'b1, 2'd0, 16'h0, 1'b1, 1'b0}));
        for (int j = 1; j < 4; j++) begin
            @(negedge clk);
            clr_start = (j < 3);
            #1 check($sformatf("clr%0d r1_ready", j), 32'(r1_ready), 32'd0);
            @(posedge clk); #1;
            check($sformatf("clr w%0d", j), 32'({w_flag, w_add, w_data, busy, clr_done}),
                  32'({1'b1, 2'(j), 16'h0, 1'b1, 1'b0}));
        end
        @(negedge clk);
        #1 check("clr last r1_ready", 32'(r1_ready), 32'd0);
        @(posedge clk); #1;
        check("clr_done pulse", 32'({clr_done, busy, w_flag}), 32'({1'b1, 1'b0, 1'b0}));
        check("ready with clr_done", 32'(r1_ready), 32'd1);
        @(posedge clk); #1;
        check("post-clr write", 32'({w_flag, w_add, w_data}), 32'({1'b1, 2'd2, 16'h7777}));
        check("clr_done one cycle", 32'(clr_done), 32'd0);
        check("post-clr cnt/lg", 32'({wr_cnt, last_grant}), 32'({8'd9, 1'b1}));
        @(negedge clk) r1_valid = 1'b0;

        // Reset in the middle of a sweep
        @(negedge clk) clr_start = 1'b1;
        @(posedge clk);
        @(negedge clk) clr_start = 1'b0;
        @(posedge clk); #1;
        check("mid-sweep w_add", 32'(w_add), 32'd1);
        #2 reset = 1'b0;
        #1 check_all_zero("abort");
        repeat (2) begin
            @(posedge clk); #1;
            check("abort no clr_done", 32'(clr_done), 32'd0);
        end
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("after abort idle", 32'({clr_done, busy, w_flag}), 32'd0);
        @(negedge clk);
        r0_valid = 1'b1; r0_add = 2'd1; r0_data = 16'hABCD;
        #1 check("after abort r0_ready", 32'(r0_ready), 32'd1);
        @(posedge clk); #1;
        check("after abort write", 32'({w_flag, w_add, w_data, wr_cnt, last_grant}),
              32'({1'b1, 2'd1, 16'hABCD, 8'd1, 1'b0}));
        @(negedge clk) r0_valid = 1'b0;

        // 256 back-to-back r1 transfers: counter wrap, no write gaps
        reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        rdy_cnt = 0; wf_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            r1_valid = 1'b1; r1_add = 2'($urandom_range(0, 3)); r1_data = 16'($urandom);
            #1 if (r1_ready) rdy_cnt++;
            @(posedge clk); #1;
            if (w_flag && w_add == r1_add && w_data == r1_data) wf_cnt++;
            if (i == 254) check("wr_cnt at 255", 32'(wr_cnt), 32'd255);
        end
        check("256 readies", 32'(rdy_cnt), 32'd256);
        check("256 writes no gaps", 32'(wf_cnt), 32'd256);
        check("wr_cnt wrapped", 32'(wr_cnt), 32'd0);
        @(negedge clk) r1_valid = 1'b0;

        // Randomized run against the behavioural model
        reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        m_active = 0; m_written = 0; m_rr = 0; m_lg = 0; m_cnt = 8'd0;
        e_wa = 2'd0; e_wd = 16'h0; acc0 = 0; acc1 = 0;
        for (int i = 0; i < NREG; i++) known[i] = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!r0_valid || acc0) begin
                r0_valid = ($urandom_range(0, 3) != 0);
                r0_add = 2'($urandom_range(0, 3)); r0_data = 16'($urandom);
            end
            if (!r1_valid || acc1) begin
                r1_valid = ($urandom_range(0, 3) != 0);
                r1_add = 2'($urandom_range(0, 3)); r1_data = 16'($urandom);
            end
            clr_start = ($urandom_range(0, 15) == 0);
            e0 = !m_active && !clr_start && r0_valid && (!r1_valid || !m_rr);
            e1 = !m_active && !clr_start && r1_valid && (!r0_valid || m_rr);
            acc0 = e0; acc1 = e1;
            #1;
            check("rnd r0_ready", 32'(r0_ready), 32'(e0));
            check("rnd r1_ready", 32'(r1_ready), 32'(e1));
            e_done = 0; e_wf = 0;
            if (m_active) begin
                if (m_written == NREG) begin
                    m_active = 0; e_done = 1;
                end else begin
                    e_wf = 1; e_wa = 2'(m_written); e_wd = 16'h0; m_written++;
                end
            end else if (clr_start) begin
                m_active = 1; m_written = 1; e_wf = 1; e_wa = 2'd0; e_wd = 16'h0;
            end else if (r0_valid || r1_valid) begin
                g = (r0_valid && r1_valid) ? m_rr : r1_valid;
                e_wf = 1;
                e_wa = g ? r1_add : r0_add;
                e_wd = g ? r1_data : r0_data;
                m_cnt = m_cnt + 8'd1; m_rr = !g; m_lg = g;
            end
            if (e_wf) begin m_mem[e_wa] = e_wd; known[e_wa] = 1; end
            @(posedge clk); #1;
            check("rnd w_flag", 32'(w_flag), 32'(e_wf));
            check("rnd w_add/w_data", 32'({w_add, w_data}), 32'({e_wa, e_wd}));
            check("rnd busy/clr_done", 32'({busy, clr_done}), 32'({m_active, e_done}));
            check("rnd wr_cnt/last_grant", 32'({wr_cnt, last_grant}), 32'({m_cnt, m_lg}));
        end
        @(negedge clk);
        r0_valid = 1'b0; r1_valid = 1'b0; clr_start = 1'b0;
        #1;
        for (int i = 0; i < NREG; i++)
            if (known[i]) check($sformatf("file reg%0d", i), 32'(tb_file[i]), 32'(m_mem[i]));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
